// File: rtl/note_tone_gen_pkg.sv
// piano_pkg: note code type, low-octave half-period table and FSM encoding for note_tone_gen.
// Revision 1.0
`default_nettype none

package piano_pkg;

  typedef logic [3:0] note_code_t;

  // Half-periods in 100 MHz clk cycles, low octave, degrees do..si
  localparam int unsigned H_DO = 191110;
  localparam int unsigned H_RE = 170265;
  localparam int unsigned H_MI = 151685;
  localparam int unsigned H_FA = 143172;
  localparam int unsigned H_SO = 127551;
  localparam int unsigned H_LA = 113636;
  localparam int unsigned H_SI = 101239;

  localparam int HIGH_OCT_BIT = 3;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PLAY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/note_tone_gen_if.sv
// note_tone_gen_if: note input from keyControl and tone/status outputs.
// Revision 1.0
`default_nettype none

interface note_tone_gen_if;

  piano_pkg::note_code_t key_out;
  logic                  key_out_on;
  logic                  buzzer;
  logic                  playing;
  piano_pkg::note_code_t cur_note;

  modport master (
    output key_out,
    output key_out_on,
    input  buzzer,
    input  playing,
    input  cur_note
  );

  modport slave (
    input  key_out,
    input  key_out_on,
    output buzzer,
    output playing,
    output cur_note
  );

endinterface

`default_nettype wire

// File: rtl/note_period_rom.sv
// note_period_rom: note code to half-period lookup; the high octave halves the low-octave value.
// Revision 1.0
`default_nettype none

module note_period_rom
  import piano_pkg::*;
#(
  parameter int CNT_W = 18
) (
  input  note_code_t       note,
  output logic [CNT_W-1:0] half
);

  logic [CNT_W-1:0] base;

  always_comb begin
    base = '0;
    case (note[2:0])
      3'd1:    base = CNT_W'(H_DO);
      3'd2:    base = CNT_W'(H_RE);
      3'd3:    base = CNT_W'(H_MI);
      3'd4:    base = CNT_W'(H_FA);
      3'd5:    base = CNT_W'(H_SO);
      3'd6:    base = CNT_W'(H_LA);
      3'd7:    base = CNT_W'(H_SI);
      default: base = '0;
    endcase
    half = note[HIGH_OCT_BIT] ? (base >> 1) : base;
  end

endmodule

`default_nettype wire

// File: rtl/note_tone_gen.sv
// note_tone_gen: monophonic square-wave buzzer driver with a programmable release tail.
// Revision 1.0
`default_nettype none

module note_tone_gen
  import piano_pkg::*;
#(
  parameter int RELEASE_CYCLES = 5_000_000,
  parameter int CNT_W          = 18,
  parameter int REL_W          = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  note_tone_gen_if.slave       bus
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [REL_W-1:0] rel;
  logic             tone;
  logic             active;
  note_code_t       note;
  logic [CNT_W-1:0] half;
  logic             valid;
  logic             wrap;
  logic             rel_done;

  // Period always follows the latched note, never the live key input
  note_period_rom #(.CNT_W(CNT_W)) u_rom (
    .note (note),
    .half (half)
  );

  assign valid    = bus.key_out_on && (bus.key_out[2:0] != 3'd0);
  assign wrap     = (cnt == half - CNT_W'(1));
  assign rel_done = (rel == REL_W'(RELEASE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rel    <= '0;
      tone   <= 1'b0;
      active <= 1'b0;
      note   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tone <= 1'b0;
          if (valid) begin
            state  <= PLAY;
            note   <= bus.key_out;
            cnt    <= '0;
            tone   <= 1'b1;
            active <= 1'b1;
          end
        end
        PLAY: begin
          if (valid && (bus.key_out != note)) begin
            note <= bus.key_out;
            cnt  <= '0;
            tone <= 1'b1;
          end else begin
            if (!valid) begin
              state <= RELEASE;
              rel   <= '0;
            end
            if (wrap) begin
              cnt  <= '0;
              tone <= ~tone;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (valid) begin
            state <= PLAY;
            note  <= bus.key_out;
            cnt   <= '0;
            tone  <= 1'b1;
          end else if (rel_done) begin
            state  <= IDLE;
            tone   <= 1'b0;
            active <= 1'b0;
            note   <= '0;
            cnt    <= '0;
            rel    <= '0;
          end else begin
            rel <= rel + REL_W'(1);
            if (wrap) begin
              cnt  <= '0;
              tone <= ~tone;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          tone   <= 1'b0;
          active <= 1'b0;
          note   <= '0;
          cnt    <= '0;
          rel    <= '0;
        end
      endcase
    end
  end

  assign bus.buzzer   = tone;
  assign bus.playing  = active;
  assign bus.cur_note = note;

endmodule

`default_nettype wire
